// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and load-extension helper for the MEM stage.
package mem_pkg;

  localparam logic [1:0] LOAD_W  = 2'b00;
  localparam logic [1:0] LOAD_H  = 2'b01;
  localparam logic [1:0] LOAD_B  = 2'b10;
  localparam logic [1:0] LOAD_BU = 2'b11;

  localparam logic [1:0] STORE_W    = 2'b00;
  localparam logic [1:0] STORE_H    = 2'b01;
  localparam logic [1:0] STORE_B    = 2'b10;
  localparam logic [1:0] STORE_NONE = 2'b11;

  // Select the addressed lane(s) of a little-endian word and sign/zero extend.
  function automatic logic [31:0] extend_load(logic [31:0] word, logic [1:0] size,
                                              logic [1:0] addr_lo);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = addr_lo[1] ? word[31:16] : word[15:0];
    byte_v = 8'(word >> {addr_lo, 3'b000});
    case (size)
      LOAD_W:  extend_load = word;
      LOAD_H:  extend_load = {{16{half[15]}}, half};
      LOAD_B:  extend_load = {{24{byte_v[7]}}, byte_v};
      default: extend_load = {24'h000000, byte_v};
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs, redirect outputs and MEM/WB register outputs of the MEM stage.
interface mem_wb_stage_if;
  logic        RegWriteIn;
  logic        MemToRegIn;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic [1:0]  LoadIn;
  logic [1:0]  StoreIn;
  logic [31:0] ALUResultIn;
  logic [31:0] ReadD2In;
  logic [4:0]  InstrMuxIn;
  logic        BranchIn;
  logic        ZeroIn;
  logic        JumpIn;
  logic [31:0] AddResultIn;
  logic        PCSrcOut;
  logic [31:0] TargetOut;
  logic        FlushOut;
  logic        RegWriteOut;
  logic        MemToRegOut;
  logic [31:0] ReadDataOut;
  logic [31:0] ALUResultOut;
  logic [4:0]  WriteRegOut;

  // Upstream pipeline side: drives EX/MEM values, observes results.
  modport master (
    output RegWriteIn, MemToRegIn, MemReadIn, MemWriteIn, LoadIn, StoreIn, ALUResultIn,
           ReadD2In, InstrMuxIn, BranchIn, ZeroIn, JumpIn, AddResultIn,
    input  PCSrcOut, TargetOut, FlushOut, RegWriteOut, MemToRegOut, ReadDataOut,
           ALUResultOut, WriteRegOut
  );

  // MEM stage side.
  modport slave (
    input  RegWriteIn, MemToRegIn, MemReadIn, MemWriteIn, LoadIn, StoreIn, ALUResultIn,
           ReadD2In, InstrMuxIn, BranchIn, ZeroIn, JumpIn, AddResultIn,
    output PCSrcOut, TargetOut, FlushOut, RegWriteOut, MemToRegOut, ReadDataOut,
           ALUResultOut, WriteRegOut
  );
endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-organised data RAM with per-byte write enables, sync write, async read.
module data_mem_bytelane #(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic                     Clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [3:0][7:0] mem [DEPTH];

  // Byte-lane write on the rising edge; unselected lanes keep their contents.
  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data memory access, branch/jump redirect and the MEM/WB register.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = ""
) (
  input logic           Clk,
  input logic           Reset,
  mem_wb_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] word_addr;
  logic [1:0]    addr_lo;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [31:0]   load_data;
  logic          mem_we;

  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic [31:0] read_data_q;
  logic [31:0] alu_result_q;
  logic [4:0]  write_reg_q;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH*4 bytes.
  assign word_addr = bus.ALUResultIn[AW+1:2];
  assign addr_lo   = bus.ALUResultIn[1:0];
  assign mem_we    = bus.MemWriteIn & ~Reset;

  // Byte-enable decode and lane replication of store data.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.ReadD2In;
    unique case (bus.StoreIn)
      STORE_W: be = 4'b1111;
      STORE_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.ReadD2In[15:0]}};
      end
      STORE_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{bus.ReadD2In[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  data_mem_bytelane #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_dmem (
    .Clk   (Clk),
    .we    (mem_we),
    .be    (be),
    .addr  (word_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Pre-edge read data, so a simultaneous store is not visible to this load.
  always_comb begin
    load_data = 32'h0;
    if (bus.MemReadIn) load_data = extend_load(rdata, bus.LoadIn, addr_lo);
  end

  // Redirect is resolved here and must be visible in the same cycle.
  always_comb begin
    bus.PCSrcOut  = (bus.BranchIn & bus.ZeroIn) | bus.JumpIn;
    bus.FlushOut  = bus.PCSrcOut;
    bus.TargetOut = bus.AddResultIn;
  end

  // MEM/WB pipeline register, captured every cycle out of reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      write_reg_q  <= 5'h0;
    end else begin
      reg_write_q  <= bus.RegWriteIn;
      mem_to_reg_q <= bus.MemToRegIn;
      read_data_q  <= load_data;
      alu_result_q <= bus.ALUResultIn;
      write_reg_q  <= bus.InstrMuxIn;
    end
  end

  assign bus.RegWriteOut  = reg_write_q;
  assign bus.MemToRegOut  = mem_to_reg_q;
  assign bus.ReadDataOut  = read_data_q;
  assign bus.ALUResultOut = alu_result_q;
  assign bus.WriteRegOut  = write_reg_q;

endmodule
